// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and fetch stage with branch squash, stall hold and halt
module pc_fetch #(
    parameter int              PC_W       = 8,
    parameter int              IW         = 9,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            is_branch,
    input  logic            branch_result,
    input  logic [PC_W-1:0] br_target,
    input  logic            halt_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    output logic [IW-1:0]   instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    output logic            done,
    output logic [15:0]     instr_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t          state, state_d;
    logic [PC_W-1:0] pc, pc_d;
    logic [PC_W-1:0] f_pc, f_pc_d;
    logic            f_valid, f_valid_d;
    logic [15:0]     count_d;
    logic            retire, halt, taken;

    assign instr       = imem_rdata;
    assign instr_pc    = f_pc;
    assign instr_valid = (state == RUN) && f_valid;
    assign done        = (state == HALTED);
    assign retire      = instr_valid && !stall;
    assign halt        = retire && halt_req;
    assign taken       = retire && is_branch && branch_result;

    // During a stall the fetch address is re-issued so memory data stays aligned with f_pc.
    always_comb begin
        imem_addr = '0;
        case (state)
            RUN:     imem_addr = stall ? f_pc : pc;
            HALTED:  imem_addr = pc;
            default: imem_addr = '0;
        endcase
    end

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        f_pc_d    = f_pc;
        f_valid_d = f_valid;
        count_d   = instr_count;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = START_ADDR;
                    f_valid_d = 1'b0;
                    count_d   = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (retire && instr_count != 16'hFFFF)
                        count_d = instr_count + 16'd1;
                    // Halt wins over a simultaneous taken branch and freezes pc.
                    if (halt) begin
                        state_d   = HALTED;
                        f_valid_d = 1'b0;
                    end else if (taken) begin
                        pc_d      = br_target;
                        f_pc_d    = pc;
                        f_valid_d = 1'b0;
                    end else begin
                        pc_d      = pc + PC_W'(1);
                        f_pc_d    = pc;
                        f_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            f_pc        <= '0;
            f_valid     <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            f_pc        <= f_pc_d;
            f_valid     <= f_valid_d;
            instr_count <= count_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - scoreboard bench for pc_fetch
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stall, is_branch, branch_result, halt_req;
    logic [7:0]  br_target, imem_addr, instr_pc;
    logic [8:0]  imem_rdata, instr;
    logic        instr_valid, done;
    logic [15:0] instr_count;
    logic        br_en, halt_en;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .is_branch(is_branch), .branch_result(branch_result), .br_target(br_target),
        .halt_req(halt_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .done(done), .instr_count(instr_count)
    );

    function automatic logic [8:0] rom_f(input logic [7:0] a);
        return {a[0] ^ a[7], a ^ 8'hA5};
    endfunction

    always @(posedge clk) imem_rdata <= rom_f(imem_addr);

    // Downstream decode: BNZ at 0x05 (-> 0x20) and at 0x22 (-> 0x40); HALT at 0x22.
    assign is_branch = br_en && (instr_pc == 8'h05 || instr_pc == 8'h22);
    assign br_target = (instr_pc == 8'h05) ? 8'h20 : 8'h40;
    assign halt_req  = halt_en && (instr_pc == 8'h22);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && instr_valid && !stall) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire", 32'(instr_pc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("retire_pc", 32'(instr_pc), 32'(e.pc));
                chk("retire_instr", 32'(instr), 32'(rom_f(e.pc)));
                chk("retire_count", 32'(instr_count), 32'(e.cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [7:0] p);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            if (instr_valid && instr_pc == p) ok = 1;
        end
        chk("wait_pc_timeout", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_result = 1'b1;
        br_en = 1'b1; halt_en = 1'b1;
        #12;
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_addr", 32'(imem_addr), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("idle_valid", 32'(instr_valid), 32'd0);

        // Sequential 0..5, stall on 4, branch 5 -> 0x20, halt+branch at 0x22
        for (int i = 0; i < 6; i++) exp_q.push_back('{8'(i), 16'(i)});
        exp_q.push_back('{8'h20, 16'd6});
        exp_q.push_back('{8'h21, 16'd7});
        exp_q.push_back('{8'h22, 16'd8});
        pulse_start();
        chk("first_fetch_bubble", 32'(instr_valid), 32'd0);
        step();
        chk("first_valid_pc", 32'(instr_valid ? instr_pc : 8'hEE), 32'd0);
        wait_pc(8'h04);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc", 32'(instr_pc), 32'd4);
            chk("stall_instr", 32'(instr), 32'(rom_f(8'h04)));
            chk("stall_count", 32'(instr_count), 32'd4);
            chk("stall_addr", 32'(imem_addr), 32'd4);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_pc", 32'(instr_pc), 32'd4);
        wait_pc(8'h05);
        step();
        chk("branch_bubble", 32'(instr_valid), 32'd0);
        step();
        chk("branch_target_pc", 32'(instr_valid ? instr_pc : 8'hEE), 32'h20);
        wait_pc(8'h22);
        step();
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_count", 32'(instr_count), 32'd9);
        chk("halt_addr", 32'(imem_addr), 32'h23);
        step();
        step();
        chk("halt_hold_addr", 32'(imem_addr), 32'h23);
        chk("halt_hold_count", 32'(instr_count), 32'd9);

        // Restart and run through the 0xFF -> 0x00 wrap
        br_en = 1'b0; halt_en = 1'b0;
        for (int i = 0; i < 259; i++) exp_q.push_back('{8'(i), 16'(i)});
        pulse_start();
        chk("restart_count", 32'(instr_count), 32'd0);
        chk("restart_done", 32'(done), 32'd0);
        wait_pc(8'hFF);
        step();
        chk("wrap_pc", 32'(instr_valid ? instr_pc : 8'hEE), 32'h00);
        wait_pc(8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_addr", 32'(imem_addr), 32'd0);
        chk("async_count", 32'(instr_count), 32'd0);
        chk("async_pc", 32'(instr_pc), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("post_reset_valid", 32'(instr_valid), 32'd0);
        chk("post_reset_done", 32'(done), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
